// File: rtl/ps2_host_tx.sv
// ps2_host_tx
//   PS/2 host-to-device transmitter. It sends one command byte (for example 0xF4
//   or 0xFF) to the device over the shared open-drain clock and data lines. The
//   outputs are open-drain enables, and the top level ORs them with the enables
//   of the receive path.
//
//   Optional feature: define PS2_HOST_TX_RETRY_EN to retry a failed frame
//   (NACK or timeout) up to two more times before reporting tx_err.
//
// Ports
//   clk          100 MHz clock
//   rst          asynchronous reset, active low
//   tx_data      command byte, latched when tx_valid && tx_ready
//   tx_valid     send request
//   tx_ready     idle, a request is accepted
//   tx_done      one-cycle pulse: device ACKed and both lines returned high
//   tx_err       one-cycle pulse: NACK or timeout
//   ps2_clk_in   raw clock pin level
//   ps2_data_in  raw data pin level
//   ps2_clk_oe   1 = pull clock pin low
//   ps2_data_oe  1 = pull data pin low
module ps2_host_tx #(
    parameter int INHIBIT_CYC = 12000,
    parameter int TIMEOUT_CYC = 2000000,
    parameter int FILTER_LEN  = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx_err,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);

    localparam int INH_W = $clog2(INHIBIT_CYC + 1);
    localparam int WD_W  = $clog2(TIMEOUT_CYC + 1);
    localparam int FC_W  = $clog2(FILTER_LEN + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_INHIBIT, S_REQ, S_SHIFT, S_ACK, S_WAIT_IDLE, S_DONE, S_ERR
    } state_t;

    // ---------------- input conditioning ----------------
    // Bit 0 is the clock line, bit 1 the data line. Lines idle high, so all
    // conditioning flops reset to 1 to avoid a false edge after reset.
    logic [1:0]      pin_raw;
    logic [1:0]      sync1_q, sync2_q, filt_q;
    logic            clk_prev_q;
    logic [FC_W-1:0] fcnt_q [2];
    logic            fall;

    assign pin_raw = {ps2_data_in, ps2_clk_in};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q    <= 2'b11;
            sync2_q    <= 2'b11;
            filt_q     <= 2'b11;
            clk_prev_q <= 1'b1;
            fcnt_q[0]  <= '0;
            fcnt_q[1]  <= '0;
        end else begin
            sync1_q    <= pin_raw;
            sync2_q    <= sync1_q;
            clk_prev_q <= filt_q[0];
            // A new level is accepted after FILTER_LEN consecutive samples
            // that differ from the current filtered level.
            for (int i = 0; i < 2; i++) begin
                if (sync2_q[i] == filt_q[i]) begin
                    fcnt_q[i] <= '0;
                end else if (fcnt_q[i] == FC_W'(FILTER_LEN - 1)) begin
                    filt_q[i] <= sync2_q[i];
                    fcnt_q[i] <= '0;
                end else begin
                    fcnt_q[i] <= fcnt_q[i] + 1'b1;
                end
            end
        end
    end

    assign fall = clk_prev_q & ~filt_q[0];

    // ---------------- FSM ----------------
    state_t           state_q, state_d;
    logic [INH_W-1:0] inh_cnt_q, inh_cnt_d;
    logic [WD_W-1:0]  wd_q, wd_d;
    logic [3:0]       n_q, n_d;
    logic [7:0]       byte_q, byte_d;
    logic             par_q, par_d;
    logic             dbit_q, dbit_d;
    logic             fail;
    logic             wd_active, wd_expired, inh_last;
`ifdef PS2_HOST_TX_RETRY_EN
    logic [1:0]       retry_q, retry_d;
`endif

    assign wd_active  = (state_q == S_REQ) || (state_q == S_SHIFT) ||
                        (state_q == S_ACK) || (state_q == S_WAIT_IDLE);
    assign wd_expired = (wd_q == WD_W'(TIMEOUT_CYC - 1));
    assign inh_last   = (inh_cnt_q == INH_W'(INHIBIT_CYC - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            inh_cnt_q <= '0;
            wd_q      <= '0;
            n_q       <= '0;
            byte_q    <= '0;
            par_q     <= 1'b0;
            dbit_q    <= 1'b0;
`ifdef PS2_HOST_TX_RETRY_EN
            retry_q   <= '0;
`endif
        end else begin
            state_q   <= state_d;
            inh_cnt_q <= inh_cnt_d;
            wd_q      <= wd_d;
            n_q       <= n_d;
            byte_q    <= byte_d;
            par_q     <= par_d;
            dbit_q    <= dbit_d;
`ifdef PS2_HOST_TX_RETRY_EN
            retry_q   <= retry_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        inh_cnt_d = '0;
        n_d       = n_q;
        byte_d    = byte_q;
        par_d     = par_q;
        dbit_d    = dbit_q;
        fail      = 1'b0;
`ifdef PS2_HOST_TX_RETRY_EN
        retry_d   = retry_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (tx_valid) begin
                    byte_d  = tx_data;
                    par_d   = ~^tx_data;
                    state_d = S_INHIBIT;
`ifdef PS2_HOST_TX_RETRY_EN
                    retry_d = 2'd0;
`endif
                end
            end
            S_INHIBIT: begin
                if (inh_last) state_d = S_REQ;
                else          inh_cnt_d = inh_cnt_q + 1'b1;
            end
            S_REQ: begin
                // First device falling edge: start bit already on the line,
                // put data bit 0 out.
                if (fall) begin
                    n_d     = 4'd1;
                    dbit_d  = ~byte_q[0];
                    state_d = S_SHIFT;
                end else if (wd_expired) begin
                    fail = 1'b1;
                end
            end
            S_SHIFT: begin
                // n_q counts edges already seen; the next bit index equals n_q.
                if (fall) begin
                    n_d = n_q + 4'd1;
                    if (n_q <= 4'd7) begin
                        dbit_d = ~byte_q[n_q[2:0]];
                    end else if (n_q == 4'd8) begin
                        dbit_d = ~par_q;
                    end else begin
                        dbit_d  = 1'b0;
                        state_d = S_ACK;
                    end
                end else if (wd_expired) begin
                    fail = 1'b1;
                end
            end
            S_ACK: begin
                if (fall) begin
                    if (filt_q[1]) fail = 1'b1;
                    else           state_d = S_WAIT_IDLE;
                end else if (wd_expired) begin
                    fail = 1'b1;
                end
            end
            S_WAIT_IDLE: begin
                if (filt_q == 2'b11) state_d = S_DONE;
                else if (wd_expired) fail = 1'b1;
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (fail) begin
`ifdef PS2_HOST_TX_RETRY_EN
            if (retry_q != 2'd2) begin
                retry_d = retry_q + 2'd1;
                state_d = S_INHIBIT;
            end else begin
                state_d = S_ERR;
            end
`else
            state_d = S_ERR;
`endif
        end

        // Watchdog restarts on every device edge and on every state change.
        wd_d = (state_d != state_q || fall || !wd_active) ? '0 : wd_q + 1'b1;
    end

    always_comb begin
        tx_ready    = (state_q == S_IDLE);
        tx_done     = (state_q == S_DONE);
        tx_err      = (state_q == S_ERR);
        ps2_clk_oe  = (state_q == S_INHIBIT);
        ps2_data_oe = 1'b0;
        case (state_q)
            S_INHIBIT: ps2_data_oe = inh_last;
            S_REQ:     ps2_data_oe = 1'b1;
            S_SHIFT:   ps2_data_oe = dbit_q;
            default:   ps2_data_oe = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
module tb_ps2_host_tx;

    localparam int INH  = 12000;
    localparam int TMO  = 3000;
    localparam int FLEN = 8;
    localparam int HP   = 40;
`ifdef PS2_HOST_TX_RETRY_EN
    localparam int ATTEMPTS = 3;
`else
    localparam int ATTEMPTS = 1;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, tx_done, tx_err, ps2_clk_oe, ps2_data_oe;
    logic       dev_clk_low = 1'b0;
    logic       dev_data_low = 1'b0;
    logic       clk_pin, data_pin;

    int checks = 0;
    int errors = 0;
    int done_seen = 0;
    int err_seen = 0;
    int inh_starts = 0;
    logic prev_pulse = 1'b0;
    logic prev_oe = 1'b0;
    logic ready_after = 1'b0;

    assign clk_pin  = ~(ps2_clk_oe | dev_clk_low);
    assign data_pin = ~(ps2_data_oe | dev_data_low);

    ps2_host_tx #(
        .INHIBIT_CYC(INH),
        .TIMEOUT_CYC(TMO),
        .FILTER_LEN (FLEN)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .tx_done    (tx_done),
        .tx_err     (tx_err),
        .ps2_clk_in (clk_pin),
        .ps2_data_in(data_pin),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe)
    );

    always #5 clk = ~clk;

    // Pulse counters and the tx_ready level in the cycle after a pulse.
    always @(negedge clk) begin
        if (tx_done === 1'b1) done_seen++;
        if (tx_err === 1'b1) err_seen++;
        if (prev_pulse) ready_after = tx_ready;
        prev_pulse = (tx_done === 1'b1) || (tx_err === 1'b1);
        if (ps2_clk_oe === 1'b1 && prev_oe !== 1'b1) inh_starts++;
        prev_oe = ps2_clk_oe;
    end

    task automatic issue(input logic [7:0] b);
        @(negedge clk);
        tx_data  = b;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    // Counts the cycles the host holds the clock low; returns at the first REQ cycle.
    task automatic wait_req(output int inh, output logic oe_req);
        inh = 0;
        while (ps2_clk_oe === 1'b1 && inh < INH + 100) begin
            inh++;
            @(negedge clk);
        end
        oe_req = ps2_data_oe;
    endtask

    // Device model: generates up to 11 clock pulses, samples the data pin in
    // each low phase, optionally ACKs after edge 10.
    task automatic dev_run(input bit ack, input int abort_edge, input bit glitch,
                           input bit poke, output logic [9:0] bits, output logic poke_ok);
        bits    = '0;
        poke_ok = 1'b1;
        repeat (30) @(negedge clk);
        if (glitch) begin
            dev_clk_low = 1'b1;
            repeat (4) @(negedge clk);
            dev_clk_low = 1'b0;
            repeat (30) @(negedge clk);
        end
        for (int k = 1; k <= 11; k++) begin
            dev_clk_low = 1'b1;
            repeat (25) @(negedge clk);
            if (k <= 10) bits[k-1] = data_pin;
            if (poke && k == 3) begin
                tx_data  = 8'hFF;
                tx_valid = 1'b1;
                @(negedge clk);
                tx_valid = 1'b0;
                poke_ok  = (ps2_clk_oe === 1'b0) && (tx_ready === 1'b0);
            end
            if (k == abort_edge) return;
            repeat (15) @(negedge clk);
            dev_clk_low = 1'b0;
            if (k == 10 && ack) dev_data_low = 1'b1;
            repeat (HP) @(negedge clk);
        end
        dev_data_low = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if (tx_ready !== 1'b1 || tx_done !== 1'b0 || tx_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: ready=%b done=%b err=%b want 1 0 0", tx_ready, tx_done, tx_err);
        end
        checks++;
        if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0) begin
            errors++;
            $display("FAIL reset_oe: clk_oe=%b data_oe=%b want 0 0", ps2_clk_oe, ps2_data_oe);
        end
        rst = 1'b1;
        repeat (20) @(negedge clk);
        checks++;
        if (tx_ready !== 1'b1 || ps2_clk_oe !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_idle: ready=%b clk_oe=%b want 1 0", tx_ready, ps2_clk_oe);
        end
    endtask

    task automatic test_send(input string name, input logic [7:0] b,
                             input logic [9:0] exp_bits, input bit glitch);
        int inh, cyc, d0, e0;
        logic oe_req, pk;
        logic [9:0] bits;
        d0 = done_seen;
        e0 = err_seen;
        issue(b);
        checks++;
        if (ps2_clk_oe !== 1'b1 || tx_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s_accept: clk_oe=%b ready=%b want 1 0", name, ps2_clk_oe, tx_ready);
        end
        wait_req(inh, oe_req);
        checks++;
        if (inh !== INH) begin
            errors++;
            $display("FAIL %s_inhibit_len: got %0d want %0d", name, inh, INH);
        end
        checks++;
        if (oe_req !== 1'b1) begin
            errors++;
            $display("FAIL %s_start_bit: data_oe=%b want 1", name, oe_req);
        end
        dev_run(1'b1, 0, glitch, 1'b0, bits, pk);
        checks++;
        if (bits !== exp_bits) begin
            errors++;
            $display("FAIL %s_frame_bits: got %b want %b", name, bits, exp_bits);
        end
        cyc = 0;
        while (tx_done !== 1'b1 && cyc < 500) begin
            cyc++;
            @(negedge clk);
        end
        checks++;
        if (tx_done !== 1'b1) begin
            errors++;
            $display("FAIL %s_done_seen: tx_done=%b want 1 within 500 cycles", name, tx_done);
        end
        @(negedge clk);
        checks++;
        if (tx_ready !== 1'b1 || tx_done !== 1'b0) begin
            errors++;
            $display("FAIL %s_ready_after_done: ready=%b done=%b want 1 0", name, tx_ready, tx_done);
        end
        repeat (20) @(negedge clk);
        checks++;
        if (done_seen - d0 !== 1 || err_seen - e0 !== 0) begin
            errors++;
            $display("FAIL %s_pulse_count: done=%0d err=%0d want 1 0", name, done_seen - d0, err_seen - e0);
        end
    endtask

    task automatic test_nack();
        int inh, d0, e0, s0;
        logic oe_req, pk;
        logic [9:0] bits;
        d0 = done_seen;
        e0 = err_seen;
        s0 = inh_starts;
        issue(8'hF4);
        for (int a = 0; a < ATTEMPTS; a++) begin
            wait_req(inh, oe_req);
            dev_run(1'b0, 0, 1'b0, 1'b0, bits, pk);
        end
        repeat (20) @(negedge clk);
        checks++;
        if (err_seen - e0 !== 1 || done_seen - d0 !== 0) begin
            errors++;
            $display("FAIL nack_pulses: err=%0d done=%0d want 1 0", err_seen - e0, done_seen - d0);
        end
        checks++;
        if (inh_starts - s0 !== ATTEMPTS) begin
            errors++;
            $display("FAIL nack_attempts: got %0d want %0d", inh_starts - s0, ATTEMPTS);
        end
        checks++;
        if (ready_after !== 1'b1 || tx_ready !== 1'b1) begin
            errors++;
            $display("FAIL nack_ready: after_pulse=%b now=%b want 1 1", ready_after, tx_ready);
        end
    endtask

    task automatic test_timeout();
        int inh, cyc;
        logic oe_req;
        issue(8'hFF);
        for (int a = 0; a < ATTEMPTS; a++) begin
            wait_req(inh, oe_req);
            cyc = 0;
            while (tx_err !== 1'b1 && ps2_clk_oe !== 1'b1 && cyc < TMO + 100) begin
                cyc++;
                @(negedge clk);
            end
            checks++;
            if (cyc !== TMO) begin
                errors++;
                $display("FAIL timeout_len: got %0d want %0d", cyc, TMO);
            end
        end
        checks++;
        if (tx_err !== 1'b1 || ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0) begin
            errors++;
            $display("FAIL timeout_err: err=%b clk_oe=%b data_oe=%b want 1 0 0", tx_err, ps2_clk_oe, ps2_data_oe);
        end
        @(negedge clk);
        checks++;
        if (tx_ready !== 1'b1 || tx_err !== 1'b0) begin
            errors++;
            $display("FAIL timeout_ready: ready=%b err=%b want 1 0", tx_ready, tx_err);
        end
    endtask

    task automatic test_midframe_reset();
        int inh, d0, e0;
        logic oe_req, pk;
        logic [9:0] bits;
        d0 = done_seen;
        e0 = err_seen;
        issue(8'h00);
        wait_req(inh, oe_req);
        dev_run(1'b1, 5, 1'b0, 1'b1, bits, pk);
        checks++;
        if (pk !== 1'b1) begin
            errors++;
            $display("FAIL blocked_valid: request during shift was accepted");
        end
        checks++;
        if (bits[4:0] !== 5'b00000 || ps2_data_oe !== 1'b1) begin
            errors++;
            $display("FAIL midframe_bits: got %b data_oe=%b want 00000 1", bits[4:0], ps2_data_oe);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0 || tx_ready !== 1'b1) begin
            errors++;
            $display("FAIL async_reset: clk_oe=%b data_oe=%b ready=%b want 0 0 1", ps2_clk_oe, ps2_data_oe, tx_ready);
        end
        dev_clk_low = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (50) @(negedge clk);
        checks++;
        if (done_seen - d0 !== 0 || err_seen - e0 !== 0 || tx_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_no_pulse: done=%0d err=%0d ready=%b want 0 0 1", done_seen - d0, err_seen - e0, tx_ready);
        end
    endtask

    initial begin
        test_reset();
        test_send("f4", 8'hF4, 10'b1_0_11110100, 1'b1);
        repeat (50) @(negedge clk);
        test_send("ff", 8'hFF, 10'b1_1_11111111, 1'b0);
        repeat (50) @(negedge clk);
        test_send("zero", 8'h00, 10'b1_1_00000000, 1'b0);
        repeat (50) @(negedge clk);
        test_nack();
        repeat (50) @(negedge clk);
        test_timeout();
        repeat (50) @(negedge clk);
        test_midframe_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

PS/2 host-to-device transmitter. It sends command bytes to the mouse, for example 0xF4 (enable data reporting) or 0xFF (reset), over the shared open-drain `ps2_clk` and `ps2_data` lines. It is the transmit counterpart of the existing PS/2 mouse receive path and runs in the 100 MHz `pclk100M` domain. The top level combines its open-drain enables with the receive path's enables on the same pins.

## Interface

**Parameters**
- `INHIBIT_CYC`, default 12000: clock-inhibit hold time in clk cycles (120 µs at 100 MHz).
- `TIMEOUT_CYC`, default 2000000: maximum gap between device clock edges before abort (20 ms).
- `FILTER_LEN`, default 8: number of consecutive equal samples needed to accept a line level.

**Ports**
- `clk`, in, 1: 100 MHz clock.
- `rst`, in, 1: reset, asynchronous and active-low.
- `tx_data`, in, 8: command byte.
- `tx_valid`, in, 1: request to send. Accepted when `tx_ready`=1.
- `tx_ready`, out, 1: block is idle and can accept a byte.
- `tx_done`, out, 1: one-cycle pulse when the device acknowledged the byte and both lines have returned to idle.
- `tx_err`, out, 1: one-cycle pulse on NACK or timeout.
- `ps2_clk_in`, in, 1: raw level of the clock pin.
- `ps2_data_in`, in, 1: raw level of the data pin.
- `ps2_clk_oe`, out, 1: 1 = drive the clock pin low, 0 = release it.
- `ps2_data_oe`, out, 1: 1 = drive the data pin low, 0 = release it.

## Operation

**Input conditioning**
- Each line passes through a 2-flop synchronizer, then a `FILTER_LEN` glitch filter.
- A device clock falling edge (`fall`) is the filtered clock going 1→0.

**Frame encoding**
- Frame = 8 data bits LSB first, then an odd-parity bit equal to `~^tx_data`, then a stop bit (data released).
- Rule for each driven bit: `ps2_data_oe` = inverse of the bit value.

**State machine**
- **IDLE**
  - `tx_ready`=1 and both enables are 0.
  - On `tx_valid`: latch `tx_data`, compute parity, go to INHIBIT.
- **INHIBIT**
  - `ps2_clk_oe`=1 for exactly `INHIBIT_CYC` cycles.
  - In the last cycle, set `ps2_data_oe`=1 (start bit 0), then go to REQ.
- **REQ**
  - `ps2_clk_oe`=0 and `ps2_data_oe`=1.
  - Wait for `fall`, which is edge 1, then go to SHIFT.
- **SHIFT**
  - The 4-bit edge counter `n` increments on each `fall`.
  - At edges 1–8, drive data bits 0–7; at edge 9, drive parity; at edge 10, release data (stop bit).
  - Go to ACK.
- **ACK**
  - Sample the filtered data at `fall` 11.
  - Sample 0 (ACK): go to WAIT_IDLE.
  - Sample 1 (NACK): go to ERR.
- **WAIT_IDLE**
  - Wait for filtered clock = 1 and filtered data = 1.
  - Then pulse `tx_done` and go to IDLE.
- **ERR**
  - Release both lines, pulse `tx_err`, go to IDLE.

**Timeout**
- The watchdog runs in REQ, SHIFT, ACK and WAIT_IDLE.
- It clears on every `fall` and on entry to each of these states.
- When it reaches `TIMEOUT_CYC`, go to ERR.

**Boundary conditions**
- While not in IDLE, `tx_valid` is ignored; no queue exists.
- `tx_valid` in the same cycle as the return to IDLE is accepted on the next cycle.
- Reset at any time, including mid-frame: both enables drop to 0 immediately (asynchronously) and the FSM returns to IDLE. No pulse is issued.

## Timing

**Reset values**
- `tx_ready`=1.
- `tx_done`, `tx_err`, `ps2_clk_oe`, `ps2_data_oe` = 0.

**Latencies**
- `tx_valid` accepted at cycle t: `ps2_clk_oe` rises at t+1, and `tx_ready` falls at t+1.
- `ps2_clk_oe` falls at t+1+`INHIBIT_CYC`.
- Data changes are registered one cycle after the filtered `fall` is detected. Total lag from the pin edge is 3+`FILTER_LEN` cycles, well inside the device's half-period of ≥30 µs.
- `tx_done` is asserted one cycle after both filtered lines are seen high in WAIT_IDLE.
- `tx_err` is asserted one cycle after the NACK sample or the timeout expiry.
- `tx_ready` returns to 1 in the cycle after a `tx_done` or `tx_err` pulse.

## Configuration

- **`PS2_HOST_TX_RETRY_EN`**
  - Defined: on NACK or timeout, re-enter INHIBIT using the latched byte, up to 2 retries (3 attempts in total). `tx_err` pulses only after the third failure. Reset clears the retry counter.
  - Undefined: the first failure pulses `tx_err`, and no retry logic is synthesized.

## Test plan

- **Send 0xF4 with the device model ACKing:**
  - `ps2_clk_oe` high for exactly 12000 cycles.
  - Data bits observed 0,0,1,0,1,1,1,1, parity 0, stop released.
  - `tx_done` pulses once; `tx_err` stays 0.
- **Send 0xFF:** parity bit = 1, i.e. `ps2_data_oe`=0 after edge 9, and `tx_done` pulses.
- **Send 0x00:** parity bit = 1; all 8 data bits have `ps2_data_oe`=1.
- **Model NACKs (data high at edge 11):**
  - Macro undefined: a single `tx_err` pulse; `tx_ready`=1 on the next cycle.
  - Macro defined: three full INHIBIT sequences, then one `tx_err` pulse.
- **Model never clocks after the request:** `tx_err` pulses 2000000 cycles after entering REQ, and both enables are 0.
- **Mid-frame reset and blocked requests:**
  - Assert `rst`=0 after edge 5: both enables go to 0 in the same cycle, `tx_ready`=1, no pulses.
  - A `tx_valid` pulsed during SHIFT is ignored.
